// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: FSM state type,
// default operand width and the quotient reported on a divide by zero.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIX    = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;

  // Divide-by-zero quotient: all ones (-1), sliced to the operand width by users.
  localparam logic [63:0] DIV0_QUOT = {64{1'b1}};

endpackage

// File: rtl/addsub_w.sv
// Parameterised ripple-carry adder/subtractor used for the trial subtraction.
// op=1 computes a - b (b inverted, carry-in set); c_out=1 then means no borrow.
module addsub_w #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         op,
  output logic [N-1:0] sum,
  output logic         c_out
);

  // Ripple the carry bit by bit through N full adders.
  always_comb begin
    logic carry;
    logic bx;
    carry = op;
    bx    = 1'b0;
    sum   = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      bx     = b[i] ^ op;
      sum[i] = a[i] ^ bx ^ carry;
      carry  = (a[i] & bx) | (a[i] & carry) | (bx & carry);
    end
    c_out = carry;
  end

endmodule

// File: rtl/div_seq.sv
// Sequential signed divider: restoring division on magnitudes, one quotient
// bit per cycle, followed by a sign-fix cycle that registers the results.
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] quot,
  output logic signed [WIDTH-1:0] rem,
  output logic                    div0,
  output logic                    ovf
);

  localparam int               CNT_W        = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONE_W        = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W       = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] MOST_NEG_MAG = {1'b1, {(WIDTH-1){1'b0}}};

  // Two's complement negation, wrapping modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  // Magnitude of a signed operand; the most-negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      return neg_w(v);
    end else begin
      return v;
    end
  endfunction

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r;
  logic             sign_a_r, sign_b_r;
  logic [WIDTH-1:0] dvd_r;   // |a| shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dvs_r;   // |b|
  logic [WIDTH-1:0] prem_r;  // partial remainder, always below |b| between steps
  logic             busy_r, done_r, div0_r, ovf_r;
  logic [WIDTH-1:0] quot_r, rem_r;

  logic [WIDTH:0]   shifted_s, diff_s;
  logic             no_borrow_s;
  logic             unused_diff_msb_s;
  logic             fix_hold_s, fix_div0_s, fix_ovf_s;
  logic [WIDTH-1:0] fix_quot_s, fix_rem_s;

  assign shifted_s = {prem_r, dvd_r[WIDTH-1]};

  addsub_w #(.N(WIDTH + 1)) u_addsub (
    .a     (shifted_s),
    .b     ({1'b0, dvs_r}),
    .op    (1'b1),
    .sum   (diff_s),
    .c_out (no_borrow_s)
  );

  // An accepted difference is always below |b|, so its top bit is never needed.
  assign unused_diff_msb_s = diff_s[WIDTH];

  // Divide-by-zero dwells one extra cycle in FIX so its latency is two edges.
  assign fix_hold_s = (dvs_r == ZERO_W) && (cnt_r == {CNT_W{1'b0}});

  // Sign-corrected results and status flags presented to the FIX cycle.
  always_comb begin
    fix_div0_s = (dvs_r == ZERO_W);
    fix_ovf_s  = 1'b0;
    fix_quot_s = ZERO_W;
    fix_rem_s  = ZERO_W;
    if (fix_div0_s) begin
      fix_quot_s = DIV0_QUOT[WIDTH-1:0];
      fix_rem_s  = sign_a_r ? neg_w(dvd_r) : dvd_r;
    end else begin
      fix_quot_s = (sign_a_r ^ sign_b_r) ? neg_w(dvd_r) : dvd_r;
      fix_rem_s  = sign_a_r ? neg_w(prem_r) : prem_r;
      fix_ovf_s  = !(sign_a_r ^ sign_b_r) && (dvd_r == MOST_NEG_MAG);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = (b == ZERO_W) ? FIX : DIVIDE;
        end else begin
          state_s = IDLE;
        end
      end
      DIVIDE: begin
        if (cnt_r == CNT_LAST) begin
          state_s = FIX;
        end else begin
          state_s = DIVIDE;
        end
      end
      FIX: begin
        if (fix_hold_s) begin
          state_s = FIX;
        end else begin
          state_s = IDLE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Datapath: operand capture, restoring steps, and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= {CNT_W{1'b0}};
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      dvd_r    <= ZERO_W;
      dvs_r    <= ZERO_W;
      prem_r   <= ZERO_W;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      div0_r   <= 1'b0;
      ovf_r    <= 1'b0;
      quot_r   <= ZERO_W;
      rem_r    <= ZERO_W;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            sign_a_r <= a[WIDTH-1];
            sign_b_r <= b[WIDTH-1];
            dvd_r    <= mag_w(a);
            dvs_r    <= mag_w(b);
            prem_r   <= ZERO_W;
            cnt_r    <= {CNT_W{1'b0}};
            busy_r   <= 1'b1;
          end
        end
        DIVIDE: begin
          cnt_r <= cnt_r + CNT_ONE;
          dvd_r <= {dvd_r[WIDTH-2:0], no_borrow_s};
          if (no_borrow_s) begin
            prem_r <= diff_s[WIDTH-1:0];
          end else begin
            prem_r <= shifted_s[WIDTH-1:0];
          end
        end
        FIX: begin
          if (fix_hold_s) begin
            cnt_r <= cnt_r + CNT_ONE;
          end else begin
            quot_r <= fix_quot_s;
            rem_r  <= fix_rem_s;
            div0_r <= fix_div0_s;
            ovf_r  <= fix_ovf_s;
            done_r <= 1'b1;
            busy_r <= 1'b0;
          end
        end
        default: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign quot = quot_r;
  assign rem  = rem_r;
  assign div0 = div0_r;
  assign ovf  = ovf_r;

endmodule
